// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch sequencer
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   // Sequencer states; the encoding is explicit so that waveforms read consistently
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int          INSTR_W = 32;
   localparam logic [63:0] PC_INC  = 64'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Instruction-memory request/response bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
   parameter int ADDR_W = 64
);
   import fetch_pkg::*;

   logic                imem_req_o;
   logic [ADDR_W-1:0]   imem_addr_o;
   logic                imem_ready_i;
   logic [INSTR_W-1:0]  imem_instr_i;

   // Fetch controller side
   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ready_i,
      input  imem_instr_i
   );

   // Instruction memory side
   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ready_i,
      output imem_instr_i
   );

endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_pc_adder64.sv
`default_nettype none
// ============================================================================
// Module      : pc_adder64
// Description : 64-bit program-counter incrementer (pc + 4, wraps naturally)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_adder64
   import fetch_pkg::*;
(
   input  wire logic [63:0] a_i,
   output logic      [63:0] sum_o
);

   assign sum_o = a_i + PC_INC;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer: owns the PC, handshakes with a
//               variable-latency instruction memory, fills the IF/ID slot and
//               applies hazard stalls and branch redirects/flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          ADDR_W   = 64
)(
   input  wire logic                clk,
   input  wire logic                reset,
   input  wire logic                stall_i,
   input  wire logic                br_taken_i,
   input  wire logic [ADDR_W-1:0]   br_target_i,
   fetch_ctrl_if.master             imem,
   output logic                     if_valid_o,
   output logic [INSTR_W-1:0]       if_instr_o,
   output logic [ADDR_W-1:0]        if_pc_o
);

   localparam logic [ADDR_W-1:0] c_WORD_MASK = ~ADDR_W'(3);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic                 valid_q, valid_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]    slot_pc_q, slot_pc_d;
   logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
   logic [ADDR_W-1:0]    hold_pc_q, hold_pc_d;
   logic                 kill_q, kill_d;
   logic [ADDR_W-1:0]    redir_q, redir_d;

   logic                 w_req;
   logic                 w_xfer;
   logic                 w_slot_free;
   logic                 w_consume;
   logic [ADDR_W-1:0]    w_tgt;
   logic [63:0]          w_pc64;
   logic [63:0]          w_pc_inc64;
   logic [ADDR_W-1:0]    w_pc_inc;

   assign w_xfer      = w_req && imem.imem_ready_i;
   assign w_slot_free = !valid_q || !stall_i;
   assign w_consume   = valid_q && !stall_i;
   assign w_tgt       = br_target_i & c_WORD_MASK;

   // Zero-extend the PC onto the 64-bit team adder
   always_comb begin
      w_pc64                = '0;
      w_pc64[ADDR_W-1:0]    = pc_q;
   end

   pc_adder64 u_pc_add (
      .a_i   (w_pc64),
      .sum_o (w_pc_inc64)
   );

   assign w_pc_inc = w_pc_inc64[ADDR_W-1:0];

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: a branch always returns to FETCH; a blocked good transfer parks in HOLD
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = FETCH;
         FETCH:   if (!br_taken_i && w_xfer && !kill_q && !w_slot_free) state_d = HOLD;
         HOLD:    if (br_taken_i || !stall_i) state_d = FETCH;
         default: state_d = BOOT;
      endcase
   end

   // FSM output decode: the request is the only unregistered output
   always_comb begin
      w_req = (state_q == FETCH);
   end

   // Datapath next-state: slot, PC, hold buffer and kill/redirect bookkeeping
   always_comb begin
      pc_d         = pc_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      slot_pc_d    = slot_pc_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      kill_d       = kill_q;
      redir_d      = redir_q;

      if (w_consume) valid_d = 1'b0;
      if (br_taken_i) valid_d = 1'b0;

      case (state_q)
         BOOT: begin
            if (br_taken_i) pc_d = w_tgt;
         end
         FETCH: begin
            if (br_taken_i) begin
               if (w_xfer) begin
                  // Returned data belongs to the wrong path; restart at the target
                  pc_d   = w_tgt;
                  kill_d = 1'b0;
               end else begin
                  // Address must stay stable until the outstanding response lands
                  kill_d  = 1'b1;
                  redir_d = w_tgt;
               end
            end else if (w_xfer) begin
               if (kill_q) begin
                  pc_d   = redir_q;
                  kill_d = 1'b0;
               end else if (w_slot_free) begin
                  valid_d   = 1'b1;
                  instr_d   = imem.imem_instr_i;
                  slot_pc_d = pc_q;
                  pc_d      = w_pc_inc;
               end else begin
                  hold_instr_d = imem.imem_instr_i;
                  hold_pc_d    = pc_q;
                  pc_d         = w_pc_inc;
               end
            end
         end
         HOLD: begin
            if (br_taken_i) begin
               pc_d = w_tgt;
            end else if (!stall_i) begin
               valid_d   = 1'b1;
               instr_d   = hold_instr_q;
               slot_pc_d = hold_pc_q;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC[ADDR_W-1:0];
         valid_q      <= 1'b0;
         instr_q      <= '0;
         slot_pc_q    <= '0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         kill_q       <= 1'b0;
         redir_q      <= '0;
      end else begin
         pc_q         <= pc_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         slot_pc_q    <= slot_pc_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         kill_q       <= kill_d;
         redir_q      <= redir_d;
      end
   end

   assign imem.imem_req_o  = w_req;
   assign imem.imem_addr_o = pc_q;
   assign if_valid_o       = valid_q;
   assign if_instr_o       = instr_q;
   assign if_pc_o          = slot_pc_q;

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage of the pipelined CPU. It owns the program counter, issues fetch requests to a variable-latency instruction memory, and delivers fetched instructions into the IF/ID slot. It also applies stalls from the hazard unit and branch redirects/flushes from the branch-resolution stage. It replaces the free-running PC+4 / branch-mux arrangement with a handshake-aware controller.

## Interface
Parameters:
- RESET_PC, 64'h0, first fetch address after reset
- ADDR_W, 64, PC / address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall_i  input  1  hazard unit: the IF/ID slot must not advance this cycle
- br_taken_i  input  1  redirect/flush request, single-cycle pulse
- br_target_i  input  ADDR_W  redirect address; bits [1:0] are ignored and treated as 0
- imem_req_o  output  1  fetch request
- imem_addr_o  output  ADDR_W  fetch address; stable while imem_req_o=1 and imem_ready_i=0
- imem_ready_i  input  1  memory response; the transfer completes on any cycle with imem_req_o && imem_ready_i
- imem_instr_i  input  32  instruction, valid when imem_ready_i=1
- if_valid_o  output  1  IF/ID slot holds a valid instruction
- if_instr_o  output  32  IF/ID instruction
- if_pc_o  output  ADDR_W  PC of if_instr_o

## Operation
- Registers:
  - pc: current fetch address, drives imem_addr_o.
  - IF/ID slot: if_valid_o, if_instr_o, if_pc_o.
  - hold buffer: instruction plus PC.
  - kill flag.
  - redirect register.
  - FSM state.
- Slot consumption: the slot is consumed on any cycle with if_valid_o && !stall_i.
- States:
  - BOOT: imem_req_o=0. Next state is FETCH unconditionally.
  - FETCH: imem_req_o=1, imem_addr_o=pc. On a transfer that is not killed:
    - if the slot is free (!if_valid_o || !stall_i): load the slot with {instr, pc}, pc <= pc+4, stay in FETCH.
    - otherwise: write {instr, pc} to the hold buffer, pc <= pc+4, go to HOLD.
  - HOLD: imem_req_o=0. When stall_i=0: move the hold buffer into the slot and go to FETCH.
- Branch, br_taken_i=1 (highest priority, overrides stall_i):
  - The slot is cleared: if_valid_o=0 next cycle.
  - In HOLD: discard the hold buffer, pc <= target, go to FETCH.
  - In FETCH with a transfer in the same cycle: discard the returned data, pc <= target.
  - In FETCH with the request outstanding (no ready): keep imem_addr_o unchanged, set kill=1, redirect <= target.
  - In FETCH with kill already set: redirect <= target (the newest target wins).
  - In BOOT: pc <= target.
- Killed transfer (kill=1 and ready): discard the data, pc <= redirect, kill <= 0, stay in FETCH.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; no overflow flag.
- Slot with no new load: if_valid_o holds while stalled; it clears to 0 when consumed.
- Reset (asynchronous, any state, including mid-transfer):
  - state=BOOT, pc=RESET_PC, kill=0.
  - if_valid_o=0, if_instr_o=0, if_pc_o=0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - Any outstanding memory response is lost.

## Timing
- Cycle 0 is the first edge after reset deasserts: BOOT.
- Cycle 1: imem_req_o=1 with imem_addr_o=RESET_PC.
- Transfer latency: a transfer at edge N gives if_valid_o=1 and the slot contents visible after edge N.
- Throughput: with zero-wait memory (ready in the same cycle as req) and no stalls, one instruction per cycle.
- Branch flush: if_valid_o=0 in the cycle after br_taken_i.
  - Zero-wait memory: the target request appears in that same cycle.
  - Outstanding request: the target is issued in the cycle after the killed transfer completes.
- HOLD exit: the cycle stall_i drops, the hold buffer loads into the slot; imem_req_o reasserts in the following cycle.
- All outputs are registered, except imem_req_o, which is decoded from the state register.

## Structure
- Package fetch_pkg:
  - state enum {BOOT, FETCH, HOLD}
  - INSTR_W=32
  - PC_INC=64'd4
- One sub-module: pc_adder64, a 64-bit pc+4 incrementer, instantiated once. The team adder replaces the inline "+".
- Register storage: plain always_ff with asynchronous reset; no latches.

## Test plan
- Reset release with zero-wait memory -> addresses 0x0, 0x4, 0x8 requested on consecutive cycles; slot PCs match one cycle later.
- Memory with 2-cycle latency -> imem_addr_o held stable while waiting; one instruction every 3 cycles.
- stall_i held 3 cycles while a transfer completes -> FSM enters HOLD with imem_req_o=0; the held instruction appears in the slot when the stall drops; no instruction is lost or duplicated.
- br_taken_i (target 0x100) during an outstanding request -> returned data discarded, next request at 0x100, if_valid_o=0 for the flush.
- Two branches (0x200, then 0x300) before the killed transfer returns -> fetch resumes at 0x300.
- Reset asserted mid-HOLD, plus pc=64'hFFFF_FFFF_FFFF_FFFC -> all outputs at reset values immediately; the wrap case fetches 0x0 next.
